// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Execution-stage ALU. Single-cycle logic/arith codes and an
//                iterative shift-add multiply. The result sits in an output
//                register behind a valid/ready handshake so that a stalled
//                writeback path holds the unit.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  // ALU control encodings
  localparam logic [3:0] C_ALU_AND = 4'b0000;
  localparam logic [3:0] C_ALU_OR  = 4'b0001;
  localparam logic [3:0] C_ALU_ADD = 4'b0010;
  localparam logic [3:0] C_ALU_SUB = 4'b0110;
  localparam logic [3:0] C_ALU_SLT = 4'b0111;
  localparam logic [3:0] C_ALU_NOR = 4'b1100;
  localparam logic [3:0] C_ALU_MUL = 4'b1000;

  // The multiply finishes on the edge where the iteration counter holds this.
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] w_mcand_next;
  logic [WIDTH-1:0] w_mplier_next;
  logic [WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0] w_count_next;

  logic             w_out_valid_next;
  logic [WIDTH-1:0] w_result_next;
  logic             w_zero_next;
  logic             w_illegal_next;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_slt;
  logic [WIDTH-1:0] w_op_res;
  logic             w_op_illegal;
  logic [WIDTH-1:0] w_acc_step;
  logic             w_mul_last;

  // A new request is only taken when idle and the output slot is free or
  // being drained on this same edge.
  assign in_ready = (r_state == S_IDLE) && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_is_mul = (alu_ctrl == C_ALU_MUL);
  assign w_slt    = $signed(op_a) < $signed(op_b);

  // Single-cycle result and illegal-code detection for the incoming request.
  always_comb begin
    w_op_res     = '0;
    w_op_illegal = 1'b0;
    case (alu_ctrl)
      C_ALU_AND: w_op_res = op_a & op_b;
      C_ALU_OR:  w_op_res = op_a | op_b;
      C_ALU_ADD: w_op_res = op_a + op_b;
      C_ALU_SUB: w_op_res = op_a - op_b;
      C_ALU_SLT: w_op_res = {{(WIDTH-1){1'b0}}, w_slt};
      C_ALU_NOR: w_op_res = ~(op_a | op_b);
      C_ALU_MUL: w_op_res = '0;
      default:   w_op_illegal = 1'b1;
    endcase
  end

  // One shift-add step: accumulate the shifted multiplicand when the current
  // multiplier LSB is set. Only the low WIDTH bits of the product are kept.
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = (r_count == C_LAST_CNT);

  // Next-state, datapath and output-register next values.
  always_comb begin
    w_state_next     = r_state;
    w_mcand_next     = r_mcand;
    w_mplier_next    = r_mplier;
    w_acc_next       = r_acc;
    w_count_next     = r_count;
    w_out_valid_next = out_valid;
    w_result_next    = result;
    w_zero_next      = zero;
    w_illegal_next   = illegal;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            // Any previous result is being drained on this edge (or the slot
            // was already empty), so the output goes invalid while iterating.
            w_mcand_next     = op_a;
            w_mplier_next    = op_b;
            w_acc_next       = '0;
            w_count_next     = '0;
            w_out_valid_next = 1'b0;
            w_state_next     = S_MUL;
          end else begin
            // Illegal codes produce result 0, so zero follows naturally.
            w_result_next    = w_op_res;
            w_zero_next      = (w_op_res == '0);
            w_illegal_next   = w_op_illegal;
            w_out_valid_next = 1'b1;
          end
        end else if (out_valid && out_ready) begin
          w_out_valid_next = 1'b0;
        end
      end

      S_MUL: begin
        w_acc_next    = w_acc_step;
        w_mcand_next  = r_mcand << 1;
        w_mplier_next = r_mplier >> 1;
        w_count_next  = r_count + CNT_W'(1);
        if (w_mul_last) begin
          w_result_next    = w_acc_step;
          w_zero_next      = (w_acc_step == '0);
          w_illegal_next   = 1'b0;
          w_out_valid_next = 1'b1;
          w_state_next     = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Multiply working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else begin
      r_mcand  <= w_mcand_next;
      r_mplier <= w_mplier_next;
      r_acc    <= w_acc_next;
      r_count  <= w_count_next;
    end
  end

  // Output register and its valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= w_out_valid_next;
      result    <= w_result_next;
      zero      <= w_zero_next;
      illegal   <= w_illegal_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Directed self-checking bench for alu_exec_unit (WIDTH=32).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_unit #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drop_request();
    in_valid = 1'b0;
    alu_ctrl = 'x;
    op_a     = 'x;
    op_b     = 'x;
  endtask

  // Issue one single-cycle op with out_ready=1; check outputs one cycle later.
  task automatic do_single(input string tag, input logic [3:0] ctrl,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_zero,
                           input logic exp_ill);
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = ctrl; op_a = a; op_b = b;
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    drop_request();
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    check({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
  endtask

  // Issue a multiply; expect WIDTH busy cycles then the product.
  task automatic do_mul(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
    int busy;
    int vld;
    busy = 0;
    vld  = 0;
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'b1000; op_a = a; op_b = b;
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    for (int k = 1; k <= WIDTH; k++) begin
      @(negedge clk);
      if (k == 1) drop_request();
      if (!in_ready) busy++;
      if (out_valid) vld++;
    end
    check({tag, "_busy_cycles"}, busy, WIDTH);
    check({tag, "_early_vld"}, vld, 32'd0);
    @(negedge clk);
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
    check({tag, "_ill"}, {31'd0, illegal}, 32'd0);
    check({tag, "_rdy_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int drops;
    int vld_cnt;

    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    alu_ctrl  = 4'd0;
    op_a      = '0;
    op_b      = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_vld",  {31'd0, out_valid}, 32'd0);
    check("rst_res",  result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_ill",  {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;
    drop_request();
    @(negedge clk);
    check("rst_rdy",  {31'd0, in_ready}, 32'd1);
    check("idle_x_vld", {31'd0, out_valid}, 32'd0);

    // Single-cycle ops
    do_single("add",   4'b0010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0);
    do_single("sub_eq",4'b0110, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0);
    do_single("sub_wr",4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_single("slt_t", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    do_single("slt_f", 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    do_single("and",   4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
    do_single("or",    4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0);
    do_single("nor",   4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0);
    do_single("illeg", 4'b0011, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b1);
    do_single("add_c", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);

    // Multiply
    do_mul("mul1", 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
    do_mul("mul2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

    // Backpressure: ADD 1+1 with the consumer stalled
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd1; op_b = 32'd1;
    @(negedge clk);
    // Pending OR held by the producer while stalled
    alu_ctrl = 4'b0001; op_a = 32'd1; op_b = 32'd2;
    drops = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_vld", {31'd0, out_valid}, 32'd1);
      check("bp_res", result, 32'd2);
      check("bp_rdy", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_rdy_rise", {31'd0, in_ready}, 32'd1);
    if (!out_valid) drops++;
    @(negedge clk);
    drop_request();
    if (!out_valid) drops++;
    check("bp_or_res", result, 32'd3);
    check("bp_no_drop", drops, 32'd0);

    // Reset during multiply iteration 10 (result register still holds 3)
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'b1000; op_a = 32'h0001_0003; op_b = 32'd5;
    @(negedge clk);
    drop_request();
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_vld", {31'd0, out_valid}, 32'd0);
    check("rst_mid_res", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vld_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) vld_cnt++;
    end
    check("rst_mid_stale", vld_cnt, 32'd0);
    check("rst_mid_rdy", {31'd0, in_ready}, 32'd1);
    do_single("post_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-stage ALU. Consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands.
- Single-cycle codes complete in one cycle. Code 1000 (MUL, team extension) runs an iterative shift-add multiply.
- Result is held in an output register behind a valid/ready handshake. This lets the multi-cycle core stall the writeback path.

Parameters:
WIDTH, 32, operand/result width in bits (≥4)
CNT_W, $clog2(WIDTH)+1, multiply iteration counter width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept request this cycle
alu_ctrl  input  4  ALU control code
op_a  input  WIDTH  operand A (rs1)
op_b  input  WIDTH  operand B (rs2/imm)
out_valid  output  1  result register holds unconsumed result
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  registered (result == 0)
illegal  output  1  registered: code was not recognised

Behaviour:
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (mod 2^WIDTH, carry dropped)
  - 0110 SUB (A−B mod 2^WIDTH)
  - 0111 SLT (signed A<B → 1 else 0, zero-extended)
  - 1100 NOR
  - 1000 MUL (low WIDTH bits of unsigned A×B)
  - any other code is illegal.
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, zero=0, illegal=0, counter=0, multiply regs=0. Takes effect immediately, independent of clk.
- Accept: a transfer occurs on a clk edge where in_valid && in_ready.
- FSM states: IDLE, MUL.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational. It is 1 after reset.
- IDLE, accept, single-cycle or illegal code:
  - result/zero/illegal are loaded at the accept edge; out_valid=1 the next cycle (latency 1).
  - Illegal code loads result=0, zero=1, illegal=1.
- IDLE, accept, MUL:
  - Latch A into the multiplicand reg and B into the multiplier reg; clear the accumulator; counter=0; go to MUL.
  - If out_valid && out_ready on the same edge, out_valid is cleared.
- MUL state, each cycle:
  - If multiplier bit0=1, acc += multiplicand.
  - Multiplicand <<=1, multiplier >>=1, counter++.
  - On the edge where counter reaches WIDTH−1, load result=acc_next, zero, illegal=0, set out_valid=1, and return to IDLE.
  - Accept at edge N → MUL occupies WIDTH cycles → out_valid=1 in cycle N+WIDTH+1.
- Output hold: while out_valid && !out_ready, result/zero/illegal are stable and in_ready=0.
- Consumption: out_valid && out_ready at an edge with no new accept → out_valid=0. If a new single-cycle op is also accepted at that edge, out_valid stays 1 with the new result (back-to-back throughput of 1/cycle).
- alu_ctrl/op_a/op_b are ignored when no accept occurs. Operands are not required stable after the accept edge.
- Reset asserted mid-MUL: the operation is aborted, no result is produced, and the unit returns to IDLE.
- No X propagation: in_valid=0 with X operands must not disturb state.

Test Plan:
- Reset, then hold out_ready=1. ADD A=0x0000_0005, B=0x0000_0003 accepted at edge N → cycle N+1: out_valid=1, result=0x8, zero=0, illegal=0.
- SUB A=7,B=7 → result=0, zero=1. SUB A=0,B=1 → result=0xFFFF_FFFF. SLT A=0xFFFF_FFFF,B=1 → result=1. SLT A=1,B=0xFFFF_FFFF → result=0.
- AND/OR/NOR with A=0xF0F0_F0F0,B=0xFF00_FF00 → 0xF000_F000 / 0xFFF0_FFF0 / 0x000F_000F. Code 0011 → result=0, zero=1, illegal=1.
- MUL A=0x0001_0003,B=0x0000_0005 accepted at edge N → in_ready=0 for cycles N+1..N+32; out_valid=1 at cycle N+33 with result=0x0005_000F. MUL 0xFFFF_FFFF×0xFFFF_FFFF → 0x0000_0001.
- Backpressure: out_ready=0 after ADD 1+1 → out_valid stays 1, result=2 stable, in_ready=0 for 5 cycles. Raise out_ready with a pending OR 1|2 → next result=3, and out_valid never drops.
- Pull rst_n low at MUL iteration 10 → out_valid=0, result=0 immediately. After release, in_ready=1 and no stale result appears.
